gth_link_sequencer: RTL
=======================

Name: gth_link_sequencer

Overview:
Bring-up and recovery controller for the 3-lane GTH TMDS transmit path. It requests the GT reset, then waits for TX reset-done, PMA reset-done and pixel-MMCM lock. It then releases the pixel-domain reset (clk_pixel_resetn) so the 148.5→74.25 MHz FIFO fills before video is declared up. In RUN it watches lock, tx_done and FIFO underflow, and re-runs the sequence with a bounded retry count.

Parameters:
RESET_PULSE, 16, cycles gt_reset_req held high per attempt
TIMEOUT, 65536, max cycles in WAIT_DONE or WAIT_LOCK before retry
LOCK_WAIT, 1024, consecutive cycles mmcm_locked must be high
FILL_CYCLES, 8, cycles after clk_pixel_resetn release before link_up
HOLDOFF, 4096, cycles between failure and the next reset attempt
MAX_RETRIES, 7, failed attempts before FAULT (1..15)
UNDERFLOW_LIMIT, 4, underflow events in RUN that force a retry (≥1)

Ports:
txoutclk_internal  in  1  clock, 148.5 MHz BUFG_GT pixel clock
gtwiz_reset_clk_freerun_in  in  1  reset, asynchronous, active-high
enable  in  1  async level; sequencer runs while high
tx_done_async  in  1  gtwiz_reset_tx_done_out, async
txpmaresetdone_async  in  3  per-lane PMA reset done, async
mmcm_locked_async  in  1  pixel clk_wiz locked, async
fifo_underflow_async  in  1  async FIFO underflow (74.25 MHz domain)
gt_reset_req  out  1  level; drives the freerun-domain gtwiz_reset_all stretcher
clk_pixel_resetn  out  1  active-low pixel datapath/FIFO reset
link_up  out  1  high only in RUN
fault  out  1  high only in FAULT
retry_cnt  out  4  failed attempts since IDLE, saturating
state  out  3  current state encoding, for ILA/status register

Behaviour:
- Reset value of every output is 0 (state=IDLE, clk_pixel_resetn=0, retry_cnt=0).
- All *_async inputs pass through 2-flop synchronizers; all decisions use the synced values. underflow_s is rising-edge detected, 1 event per edge.
- State encoding: IDLE=0, GT_RESET=1, WAIT_DONE=2, WAIT_LOCK=3, FILL=4, RUN=5, HOLDOFF=6, FAULT=7.
- One shared down/up cycle counter, cleared on every state entry.
- IDLE: retry_cnt←0. enable_s=1 → GT_RESET.
- GT_RESET: gt_reset_req=1 for exactly RESET_PULSE cycles → WAIT_DONE.
- WAIT_DONE: tx_done_s & (&pmadone_s) → WAIT_LOCK. Counter reaching TIMEOUT → HOLDOFF.
- WAIT_LOCK: lock-run counter increments while locked_s and clears on any low cycle. Reaching LOCK_WAIT → FILL. Total TIMEOUT → HOLDOFF.
- FILL: clk_pixel_resetn=1 from the first FILL cycle. Underflow ignored. After FILL_CYCLES → RUN.
- RUN: link_up=1 and clk_pixel_resetn=1. The underflow counter clears on entry. Any of these → HOLDOFF:
  - locked_s=0
  - tx_done_s=0
  - underflow count reaching UNDERFLOW_LIMIT
- HOLDOFF: clk_pixel_resetn=0 and link_up=0 on entry cycle. retry_cnt increments once on entry, saturating at 15. If the new retry_cnt ≥ MAX_RETRIES → FAULT next cycle; else wait HOLDOFF cycles → GT_RESET.
- FAULT: fault=1, clk_pixel_resetn=0. Stays until enable_s=0.
- enable_s=0 in any state → IDLE next cycle. This has priority over every other transition. gt_reset_req and clk_pixel_resetn drop the same cycle.
- Simultaneous failures in RUN (lock loss + underflow limit) → single HOLDOFF entry, retry_cnt +1 only.
- txoutclk_internal may stall or glitch-free stop during GT reset. State and counters hold. No output may toggle without a clock edge except via async reset.
- Outputs are registered; state→output latency is 0 cycles relative to the state register. Input→response latency is 2 sync cycles + 1 FSM cycle = 3.
- Async reset mid-sequence → immediate IDLE, all outputs 0. Resumes from GT_RESET once reset is released and enable_s=1.

Test Plan:
- Bench params: RESET_PULSE=4, TIMEOUT=64, LOCK_WAIT=8, FILL_CYCLES=4, HOLDOFF=16, MAX_RETRIES=3, UNDERFLOW_LIMIT=2.
- Nominal: enable=1, done/pmadone asserted at cycle 20, lock at 30.
  - gt_reset_req high exactly 4 cycles.
  - clk_pixel_resetn rises 8 locked cycles after the synced lock.
  - link_up 4 cycles later; retry_cnt=0.
- Lock glitch in WAIT_LOCK: lock high 5 cycles, low 1, high again → FILL entered 8 cycles after the second rise, not before.
- tx_done never asserts:
  - 64-cycle timeouts cause retry_cnt 1→2→3.
  - 16-cycle holdoffs occur between attempts.
  - fault=1 after the third failure; gt_reset_req never re-asserted.
  - enable=0 then 1 → retry_cnt=0, new GT_RESET.
- RUN underflow: one underflow edge → link_up stays 1. Second edge → HOLDOFF, clk_pixel_resetn=0, retry_cnt=1, then re-sequence to RUN.
- Simultaneous lock loss + second underflow in the same cycle → retry_cnt increments by exactly 1.
- Async reset asserted in FILL, and enable=0 during GT_RESET → all outputs 0 at once / next cycle respectively, state=0.

Source files
------------

// File: rtl/gth_link_sequencer.sv
// gth_link_sequencer: GT reset, lock and FIFO-fill bring-up plus
// bounded-retry recovery for the 3-lane GTH TMDS transmit path.
module gth_link_sequencer #(
   parameter int RESET_PULSE     = 16,
   parameter int TIMEOUT         = 65536,
   parameter int LOCK_WAIT       = 1024,
   parameter int FILL_CYCLES     = 8,
   parameter int HOLDOFF         = 4096,
   parameter int MAX_RETRIES     = 7,
   parameter int UNDERFLOW_LIMIT = 4
) (
   input  logic       txoutclk_internal,
   input  logic       gtwiz_reset_clk_freerun_in,
   input  logic       enable,
   input  logic       tx_done_async,
   input  logic [2:0] txpmaresetdone_async,
   input  logic       mmcm_locked_async,
   input  logic       fifo_underflow_async,
   output logic       gt_reset_req,
   output logic       clk_pixel_resetn,
   output logic       link_up,
   output logic       fault,
   output logic [3:0] retry_cnt,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_GT_RESET  = 3'd1,
      S_WAIT_DONE = 3'd2,
      S_WAIT_LOCK = 3'd3,
      S_FILL      = 3'd4,
      S_RUN       = 3'd5,
      S_HOLDOFF   = 3'd6,
      S_FAULT     = 3'd7
   } state_t;

   localparam int M1   = (TIMEOUT > HOLDOFF) ? TIMEOUT : HOLDOFF;
   localparam int M2   = (RESET_PULSE > FILL_CYCLES) ? RESET_PULSE : FILL_CYCLES;
   localparam int CMAX = (M1 > M2) ? M1 : M2;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int LW   = $clog2(LOCK_WAIT + 1);
   localparam int UW   = $clog2(UNDERFLOW_LIMIT + 1);

   logic          clk;
   logic          rst;
   logic [6:0]    sync_a;
   logic [6:0]    sync_b;
   logic          enable_s;
   logic          tx_done_s;
   logic [2:0]    pmadone_s;
   logic          locked_s;
   logic          underflow_s;
   logic          underflow_d;
   logic          uf_evt;
   logic          run_fail;
   state_t        st;
   state_t        nxt;
   logic [CW-1:0] cnt;
   logic [LW-1:0] lock_run;
   logic [UW-1:0] uf_cnt;

   assign clk = txoutclk_internal;
   assign rst = gtwiz_reset_clk_freerun_in;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_a      <= '0;
         sync_b      <= '0;
         underflow_d <= 1'b0;
      end else begin
         sync_a      <= {fifo_underflow_async, mmcm_locked_async,
                         txpmaresetdone_async, tx_done_async, enable};
         sync_b      <= sync_a;
         underflow_d <= underflow_s;
      end
   end

   assign enable_s    = sync_b[0];
   assign tx_done_s   = sync_b[1];
   assign pmadone_s   = sync_b[4:2];
   assign locked_s    = sync_b[5];
   assign underflow_s = sync_b[6];
   assign uf_evt      = underflow_s & ~underflow_d;

   // All RUN failure causes merge into one HOLDOFF entry
   assign run_fail = ~locked_s | ~tx_done_s |
                     (uf_evt & (uf_cnt == UW'(UNDERFLOW_LIMIT - 1)));

   always_comb begin
      nxt = st;
      unique case (st)
         S_IDLE:
            if (enable_s) nxt = S_GT_RESET;
         S_GT_RESET:
            if (cnt == CW'(RESET_PULSE - 1)) nxt = S_WAIT_DONE;
         S_WAIT_DONE:
            if (tx_done_s & (&pmadone_s)) nxt = S_WAIT_LOCK;
            else if (cnt == CW'(TIMEOUT - 1)) nxt = S_HOLDOFF;
         S_WAIT_LOCK:
            if (locked_s && lock_run == LW'(LOCK_WAIT - 1))
               nxt = S_FILL;
            else if (cnt == CW'(TIMEOUT - 1)) nxt = S_HOLDOFF;
         S_FILL:
            if (cnt == CW'(FILL_CYCLES - 1)) nxt = S_RUN;
         S_RUN:
            if (run_fail) nxt = S_HOLDOFF;
         S_HOLDOFF:
            if (retry_cnt >= 4'(MAX_RETRIES)) nxt = S_FAULT;
            else if (cnt == CW'(HOLDOFF - 1)) nxt = S_GT_RESET;
         S_FAULT:
            nxt = S_FAULT;
      endcase
      if (!enable_s) nxt = S_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st       <= S_IDLE;
         cnt      <= '0;
         lock_run <= '0;
         uf_cnt   <= '0;
      end else begin
         st <= nxt;
         if (nxt != st)
            cnt <= '0;
         else if (st != S_IDLE && st != S_RUN && st != S_FAULT)
            cnt <= cnt + 1'b1;
         if (st != S_WAIT_LOCK || !locked_s)
            lock_run <= '0;
         else
            lock_run <= lock_run + 1'b1;
         if (st != S_RUN)
            uf_cnt <= '0;
         else if (uf_evt)
            uf_cnt <= uf_cnt + 1'b1;
      end
   end

   // Outputs are registered from the next state so they line up with st
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gt_reset_req     <= 1'b0;
         clk_pixel_resetn <= 1'b0;
         link_up          <= 1'b0;
         fault            <= 1'b0;
         retry_cnt        <= '0;
      end else begin
         gt_reset_req     <= (nxt == S_GT_RESET);
         clk_pixel_resetn <= (nxt == S_FILL) || (nxt == S_RUN);
         link_up          <= (nxt == S_RUN);
         fault            <= (nxt == S_FAULT);
         if (nxt == S_IDLE)
            retry_cnt <= '0;
         else if (nxt == S_HOLDOFF && st != S_HOLDOFF && retry_cnt != 4'hF)
            retry_cnt <= retry_cnt + 1'b1;
      end
   end

   assign state = st;

endmodule
